// File: rtl/adma_dm_src_axis_chk_pkg.sv
// Shared types for the DMA source stream checker: FSM states and the queued order record.
package adma_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_XFER  = 2'd1,
    ST_PAD   = 2'd2,
    ST_DRAIN = 2'd3
  } adma_state_e;

  // Order fields are stored at fixed maximum widths so one record type serves every parameterisation.
  localparam int unsigned ORD_ID_MAX_W  = 16;
  localparam int unsigned ORD_LEN_MAX_W = 16;
  localparam int unsigned ORD_CHN_MAX_W = 8;

  typedef struct packed {
    logic [ORD_ID_MAX_W-1:0]  arid;
    logic [ORD_LEN_MAX_W-1:0] arlen;
    logic [ORD_CHN_MAX_W-1:0] chn;
  } adma_order_t;

endpackage

// File: rtl/adma_dm_src_axis_chk_fifo.sv
// Synchronous first-word-fall-through FIFO holding outstanding read orders.
module sync_fifo #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/adma_dm_src_axis_chk.sv
// Checks an AXI-Stream source against queued read orders, padding short and draining long packets.
module adma_dm_src_axis_chk
  import adma_pkg::*;
#(
  parameter  int unsigned DMA_CHN_NUM    = 4,
  parameter  int unsigned ATX_SRC_DATA_W = 256,
  parameter  int unsigned MST_ID_W       = 5,
  parameter  int unsigned ATX_LEN_W      = 8,
  parameter  int unsigned ATX_NUM_OSTD   = DMA_CHN_NUM,
  localparam int unsigned CHN_W          = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
  localparam int unsigned BYTE_AMT       = ATX_SRC_DATA_W / 8
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [MST_ID_W-1:0]       atx_arid,
  input  logic [ATX_LEN_W-1:0]      atx_arlen,
  input  logic [CHN_W-1:0]          atx_chn,
  input  logic                      atx_vld,
  output logic                      atx_rdy,
  output logic [ATX_SRC_DATA_W-1:0] atx_rdata,
  output logic                      atx_rdata_last,
  output logic [CHN_W-1:0]          atx_rdata_chn,
  output logic                      atx_rdata_vld,
  input  logic                      atx_rdata_rdy,
  output logic                      atx_src_err [DMA_CHN_NUM],
  input  logic                      atx_err_clr [DMA_CHN_NUM],
  input  logic [MST_ID_W-1:0]       s_tid_i,
  input  logic [ATX_SRC_DATA_W-1:0] s_tdata_i,
  input  logic [BYTE_AMT-1:0]       s_tkeep_i,
  input  logic                      s_tlast_i,
  input  logic                      s_tvalid_i,
  output logic                      s_tready_o
);

  localparam int unsigned QCW = $clog2(ATX_NUM_OSTD) + 1;

  adma_order_t ord_wr, hd;
  logic        ord_full, ord_empty;
  logic [QCW-1:0] ord_cnt;

  adma_state_e              state_q, state_d;
  logic [ATX_LEN_W-1:0]     cnt_q, cnt_d;
  logic                     out_vld_q, out_vld_d;
  logic                     out_last_q, out_last_d;
  logic [CHN_W-1:0]         out_chn_q, out_chn_d;
  logic [ATX_SRC_DATA_W-1:0] out_data_q, out_data_d;
  logic [DMA_CHN_NUM-1:0]   err_q;

  logic [ATX_SRC_DATA_W-1:0] keep_data;
  logic push, pop, more, last_pend, out_free, is_final, tid_bad, tready, err_set;

  assign atx_rdy = !ord_full && !areset;
  assign push    = atx_vld && atx_rdy;
  assign ord_wr  = '{arid:  ORD_ID_MAX_W'(atx_arid),
                     arlen: ORD_LEN_MAX_W'(atx_arlen),
                     chn:   ORD_CHN_MAX_W'(atx_chn)};

  sync_fifo #(
    .DEPTH (ATX_NUM_OSTD),
    .WIDTH ($bits(adma_order_t))
  ) u_ord_q (
    .clk_i   (aclk),
    .rst_i   (areset),
    .push_i  (push),
    .wdata_i (ord_wr),
    .pop_i   (pop),
    .rdata_o (hd),
    .full_o  (ord_full),
    .empty_o (ord_empty),
    .count_o (ord_cnt)
  );

  // The stream stalls while the order's final beat waits in the output register, so the
  // next order's beats are only taken once the queue head has advanced.
  assign last_pend = out_vld_q && out_last_q;
  assign pop       = last_pend && atx_rdata_rdy;
  assign out_free  = !out_vld_q || atx_rdata_rdy;
  assign more      = (ord_cnt + QCW'(push) - QCW'(pop)) != '0;
  assign is_final  = (ORD_LEN_MAX_W'(cnt_q) == hd.arlen);
  assign tid_bad   = (ORD_ID_MAX_W'(s_tid_i) != hd.arid);

  always_comb begin
    keep_data = '0;
    for (int unsigned b = 0; b < BYTE_AMT; b++) begin
      if (s_tkeep_i[b]) keep_data[b*8 +: 8] = s_tdata_i[b*8 +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_vld_d  = out_vld_q && !atx_rdata_rdy;
    out_last_d = out_last_q;
    out_chn_d  = out_chn_q;
    out_data_d = out_data_q;
    tready     = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!ord_empty) begin
          state_d = ST_XFER;
          cnt_d   = '0;
        end
      end
      ST_XFER: begin
        tready = out_free && !last_pend;
        if (pop) begin
          state_d = more ? ST_XFER : ST_IDLE;
        end else if (s_tvalid_i && tready) begin
          out_vld_d  = 1'b1;
          out_data_d = keep_data;
          out_last_d = is_final;
          out_chn_d  = hd.chn[CHN_W-1:0];
          if (tid_bad) err_set = 1'b1;
          if (is_final) begin
            cnt_d = '0;
            if (!s_tlast_i) begin
              err_set = 1'b1;
              state_d = ST_DRAIN;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (s_tlast_i) begin
              err_set = 1'b1;
              state_d = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        if (out_free && !last_pend) begin
          out_vld_d  = 1'b1;
          out_data_d = '0;
          out_last_d = is_final;
          out_chn_d  = hd.chn[CHN_W-1:0];
          if (is_final) begin
            cnt_d   = '0;
            state_d = ST_XFER;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        tready = 1'b1;
        if (s_tvalid_i && s_tlast_i) begin
          if (last_pend && !atx_rdata_rdy) state_d = ST_XFER;
          else                             state_d = more ? ST_XFER : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_chn_q  <= '0;
      out_data_q <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_chn_q  <= out_chn_d;
      out_data_q <= out_data_d;
      for (int unsigned c = 0; c < DMA_CHN_NUM; c++) begin
        if (err_set && (ORD_CHN_MAX_W'(c) == hd.chn)) err_q[c] <= 1'b1;
        else if (atx_err_clr[c])                      err_q[c] <= 1'b0;
      end
    end
  end

  always_comb begin
    for (int unsigned c = 0; c < DMA_CHN_NUM; c++) atx_src_err[c] = err_q[c];
  end

  assign s_tready_o     = tready && !areset;
  assign atx_rdata_vld  = out_vld_q;
  assign atx_rdata_last = out_last_q;
  assign atx_rdata_chn  = out_chn_q;
  assign atx_rdata      = out_data_q;

endmodule

// File: tb/tb_adma_dm_src_axis_chk.sv
// Randomised bench: a packet-level model predicts output beats and per-channel errors.
module tb_adma_dm_src_axis_chk;

  localparam int unsigned CHN_N = 4;
  localparam int unsigned DW    = 256;
  localparam int unsigned IDW   = 5;
  localparam int unsigned LW    = 8;
  localparam int unsigned OSTD  = 4;
  localparam int unsigned BY    = DW / 8;
  localparam int unsigned CW    = 2;

  logic           aclk = 1'b0;
  logic           areset = 1'b1;
  logic [IDW-1:0] atx_arid = '0;
  logic [LW-1:0]  atx_arlen = '0;
  logic [CW-1:0]  atx_chn = '0;
  logic           atx_vld = 1'b0;
  logic           atx_rdy;
  logic [DW-1:0]  atx_rdata;
  logic           atx_rdata_last;
  logic [CW-1:0]  atx_rdata_chn;
  logic           atx_rdata_vld;
  logic           atx_rdata_rdy = 1'b1;
  logic           atx_src_err [CHN_N];
  logic           atx_err_clr [CHN_N];
  logic [IDW-1:0] s_tid = '0;
  logic [DW-1:0]  s_tdata = '0;
  logic [BY-1:0]  s_tkeep = '0;
  logic           s_tlast = 1'b0;
  logic           s_tvalid = 1'b0;
  logic           s_tready;

  adma_dm_src_axis_chk #(
    .DMA_CHN_NUM    (CHN_N),
    .ATX_SRC_DATA_W (DW),
    .MST_ID_W       (IDW),
    .ATX_LEN_W      (LW),
    .ATX_NUM_OSTD   (OSTD)
  ) dut (
    .aclk           (aclk),
    .areset         (areset),
    .atx_arid       (atx_arid),
    .atx_arlen      (atx_arlen),
    .atx_chn        (atx_chn),
    .atx_vld        (atx_vld),
    .atx_rdy        (atx_rdy),
    .atx_rdata      (atx_rdata),
    .atx_rdata_last (atx_rdata_last),
    .atx_rdata_chn  (atx_rdata_chn),
    .atx_rdata_vld  (atx_rdata_vld),
    .atx_rdata_rdy  (atx_rdata_rdy),
    .atx_src_err    (atx_src_err),
    .atx_err_clr    (atx_err_clr),
    .s_tid_i        (s_tid),
    .s_tdata_i      (s_tdata),
    .s_tkeep_i      (s_tkeep),
    .s_tlast_i      (s_tlast),
    .s_tvalid_i     (s_tvalid),
    .s_tready_o     (s_tready)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic          last;
    logic [CW-1:0] chn;
  } beat_t;

  beat_t       exp_q [$];
  beat_t       e;
  bit          exp_err [CHN_N];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned cyc     = 0;
  int unsigned pop_cyc = 0;
  bit          rdy_rand = 1'b0;

  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < CHN_N; i++) atx_err_clr[i] = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      atx_rdata_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: in-order comparison with the expected beat queue plus stall stability.
  logic [DW-1:0] prev_d;
  logic          prev_last;
  logic [CW-1:0] prev_chn;
  bit            prev_stall = 1'b0;

  always @(negedge aclk) begin
    if (areset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_vld",  atx_rdata_vld,  1'b1);
        check("stall_data", atx_rdata,      prev_d);
        check("stall_last", atx_rdata_last, prev_last);
        check("stall_chn",  atx_rdata_chn,  prev_chn);
      end
      if (atx_rdata_vld && atx_rdata_rdy) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", atx_rdata,      e.d);
          check("beat_last", atx_rdata_last, e.last);
          check("beat_chn",  atx_rdata_chn,  e.chn);
          if (atx_rdata_last) pop_cyc = cyc;
        end
      end
      prev_stall = atx_rdata_vld && !atx_rdata_rdy;
      prev_d     = atx_rdata;
      prev_last  = atx_rdata_last;
      prev_chn   = atx_rdata_chn;
    end
  end

  function automatic logic [DW-1:0] mask_keep(input logic [DW-1:0] d, input logic [BY-1:0] k);
    logic [DW-1:0] r = '0;
    for (int i = 0; i < BY; i++) if (k[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_order(input logic [IDW-1:0] id, input logic [LW-1:0] len, input logic [CW-1:0] chn);
    int n = 0;
    bit ok = 1'b0;
    atx_arid = id; atx_arlen = len; atx_chn = chn; atx_vld = 1'b1;
    while (!ok && n < 500) begin
      @(negedge aclk);
      ok = atx_rdy;
      step();
      n++;
    end
    atx_vld = 1'b0;
    if (!ok) check("order_timeout", 1'b0, 1'b1);
  endtask

  // Expected output per packet: first min(P,L) beats masked, zeros up to L if short; error if P!=L or TID differs.
  task automatic send_packet(input logic [IDW-1:0] id, input logic [LW-1:0] len, input logic [CW-1:0] chn,
                             input logic [IDW-1:0] tid, input int unsigned nb, input int kmode,
                             input bit wl, input bit gaps);
    int unsigned L = int'(len) + 1;
    logic [DW-1:0] d;
    logic [BY-1:0] k;
    int n;
    bit ok;
    for (int unsigned i = 0; i < nb; i++) begin
      for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom;
      k = (kmode == 0) ? '1 : (kmode == 1) ? BY'(32'h0F) : BY'($urandom);
      if (i < L) exp_q.push_back('{d: mask_keep(d, k), last: (i == L - 1), chn: chn});
      s_tid = tid; s_tdata = d; s_tkeep = k; s_tlast = wl && (i == nb - 1); s_tvalid = 1'b1;
      n = 0; ok = 1'b0;
      while (!ok && n < 500) begin
        @(negedge aclk);
        ok = s_tready;
        step();
        n++;
      end
      s_tvalid = 1'b0;
      if (!ok) check("beat_timeout", 1'b0, 1'b1);
      if (gaps && ($urandom_range(0, 2) == 0)) step();
    end
    if (wl && nb < L)
      for (int unsigned j = nb; j < L; j++) exp_q.push_back('{d: '0, last: (j == L - 1), chn: chn});
    if ((wl && nb != L) || (tid != id)) exp_err[chn] = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge aclk);
      n++;
    end
    check({tag, "_drain"}, exp_q.size(), 0);
    step();
    step();
  endtask

  task automatic check_errs(input string tag);
    @(negedge aclk);
    for (int c = 0; c < CHN_N; c++) check($sformatf("%s_err%0d", tag, c), atx_src_err[c], exp_err[c]);
    step();
  endtask

  task automatic clear_errs();
    for (int c = 0; c < CHN_N; c++) atx_err_clr[c] = 1'b1;
    step();
    for (int c = 0; c < CHN_N; c++) begin
      atx_err_clr[c] = 1'b0;
      exp_err[c] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int unsigned L, nb, kind;
    logic [IDW-1:0] id, tid;
    logic [CW-1:0] chn;
    logic [LW-1:0] len;

    for (int c = 0; c < CHN_N; c++) exp_err[c] = 1'b0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_atx_rdy", atx_rdy, 1'b0);
    check("rst_tready", s_tready, 1'b0);
    step();
    areset = 1'b0;
    @(negedge aclk);
    check("rst_vld", atx_rdata_vld, 1'b0);
    check("rst_data", atx_rdata, '0);
    check("rst_last", atx_rdata_last, 1'b0);
    check("rst_chn", atx_rdata_chn, '0);
    check("idle_tready", s_tready, 1'b0);
    check("post_rst_rdy", atx_rdy, 1'b1);
    step();
    check_errs("rst");

    // Exact-length packet.
    push_order(5'd3, 8'd3, 2'd1);
    send_packet(5'd3, 8'd3, 2'd1, 5'd3, 4, 0, 1'b1, 1'b0);
    wait_idle("exact");
    check_errs("exact");

    // Early tlast: padded with zeros, sticky error on channel 1.
    push_order(5'd3, 8'd3, 2'd1);
    send_packet(5'd3, 8'd3, 2'd1, 5'd3, 2, 0, 1'b1, 1'b0);
    wait_idle("short");
    check_errs("short");
    repeat (10) step();
    check_errs("short_hold");
    clear_errs();
    check_errs("short_clr");

    // Late tlast: excess beats discarded, following order unaffected.
    push_order(5'd5, 8'd1, 2'd2);
    send_packet(5'd5, 8'd1, 2'd2, 5'd5, 4, 2, 1'b1, 1'b0);
    push_order(5'd6, 8'd2, 2'd0);
    send_packet(5'd6, 8'd2, 2'd0, 5'd6, 3, 2, 1'b1, 1'b0);
    wait_idle("long");
    check_errs("long");
    clear_errs();

    // TID mismatch.
    push_order(5'd7, 8'd2, 2'd3);
    send_packet(5'd7, 8'd2, 2'd3, 5'd8, 3, 0, 1'b1, 1'b0);
    wait_idle("tid");
    check_errs("tid");
    clear_errs();

    // Fill the order queue, then release one order.
    for (int k = 0; k < OSTD; k++) push_order(IDW'(10 + k), 8'd1, CW'(k));
    @(negedge aclk);
    check("full_rdy", atx_rdy, 1'b0);
    step();
    send_packet(5'd10, 8'd1, 2'd0, 5'd10, 2, 0, 1'b1, 1'b0);
    n = 0;
    while (n < 200) begin
      @(negedge aclk);
      if (atx_rdy) break;
      n++;
    end
    check("rdy_after_pop", cyc, pop_cyc + 1);
    step();
    for (int k = 1; k < OSTD; k++)
      send_packet(IDW'(10 + k), 8'd1, CW'(k), IDW'(10 + k), 2, 0, 1'b1, 1'b0);
    wait_idle("fill");
    check_errs("fill");

    // 64 beats under random backpressure with only the low four bytes kept.
    rdy_rand = 1'b1;
    push_order(5'd9, 8'd63, 2'd0);
    send_packet(5'd9, 8'd63, 2'd0, 5'd9, 64, 1, 1'b1, 1'b0);
    wait_idle("bp64");
    check_errs("bp64");

    // Randomised mix of normal, short, long and mismatched-TID packets.
    for (int t = 0; t < 24; t++) begin
      len  = LW'($urandom_range(0, 5));
      L    = int'(len) + 1;
      chn  = CW'($urandom);
      id   = IDW'($urandom);
      tid  = id;
      nb   = L;
      kind = $urandom_range(0, 9);
      if (kind == 6 && L > 1) nb = $urandom_range(1, L - 1);
      if (kind == 7) nb = L + $urandom_range(1, 3);
      if (kind == 8) tid = id ^ IDW'($urandom_range(1, 31));
      push_order(id, len, chn);
      send_packet(id, len, chn, tid, nb, $urandom_range(0, 2), 1'b1, 1'b1);
    end
    wait_idle("rand");
    check_errs("rand");
    clear_errs();
    rdy_rand = 1'b0;

    // Reset in the middle of an order abandons it.
    push_order(5'd1, 8'd7, 2'd0);
    send_packet(5'd1, 8'd7, 2'd0, 5'd1, 3, 0, 1'b0, 1'b0);
    wait_idle("mid");
    areset = 1'b1;
    @(negedge aclk);
    check("mid_rst_rdy", atx_rdy, 1'b0);
    step();
    step();
    areset = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      check("mid_no_beat", atx_rdata_vld, 1'b0);
      check("mid_tready", s_tready, 1'b0);
      step();
    end
    push_order(5'd2, 8'd1, 2'd1);
    send_packet(5'd2, 8'd1, 2'd1, 5'd2, 2, 0, 1'b1, 1'b0);
    wait_idle("recover");
    check_errs("recover");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adma_dm_src_axis_chk.md
ADMA_DM_SRC_AXIS_CHK -- requirements
Module: adma_dm_src_axis_chk

Interface
REQ-001 SHALL have parameter DMA_CHN_NUM, default 4, number of DMA channels (CHN_W = max(1, clog2(DMA_CHN_NUM))).
REQ-002 SHALL have parameter ATX_SRC_DATA_W, default 256, stream/data width in bits (BYTE_AMT = ATX_SRC_DATA_W/8).
REQ-003 SHALL have parameter MST_ID_W, default 5, TID/ARID width.
REQ-004 SHALL have parameter ATX_LEN_W, default 8, beat-count width (beats = arlen+1).
REQ-005 SHALL have parameter ATX_NUM_OSTD, default DMA_CHN_NUM, order-queue depth, power of two, minimum 2.
REQ-006 SHALL have port aclk  in  1  sole clock; all logic rising-edge.
REQ-007 SHALL have port areset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port atx_arid  in  MST_ID_W  expected TID of the ordered transfer.
REQ-009 SHALL have port atx_arlen  in  ATX_LEN_W  ordered beats minus one.
REQ-010 SHALL have port atx_chn  in  CHN_W  owning DMA channel.
REQ-011 SHALL have port atx_vld  in  1  order valid.
REQ-012 SHALL have port atx_rdy  out  1  order accepted; low when queue full.
REQ-013 SHALL have port atx_rdata  out  ATX_SRC_DATA_W  output beat data.
REQ-014 SHALL have port atx_rdata_last  out  1  final beat of the order.
REQ-015 SHALL have port atx_rdata_chn  out  CHN_W  channel of the current beat.
REQ-016 SHALL have port atx_rdata_vld  out  1  output beat valid.
REQ-017 SHALL have port atx_rdata_rdy  in  1  downstream ready.
REQ-018 SHALL have port atx_src_err  out  DMA_CHN_NUM (unpacked array of 1-bit)  sticky per-channel source error.
REQ-019 SHALL have port atx_err_clr  in  DMA_CHN_NUM (unpacked array of 1-bit)  per-channel error clear pulse.
REQ-020 SHALL have ports s_tid_i (MST_ID_W), s_tdata_i (ATX_SRC_DATA_W), s_tkeep_i (BYTE_AMT), s_tlast_i (1), s_tvalid_i (1), all inputs: AXI-Stream slave.
REQ-021 SHALL have port s_tready_o  out  1  AXI-Stream slave ready.

Function
REQ-022 SHALL queue orders in-order in an ATX_NUM_OSTD-deep FIFO; atx_rdy = !full; push on atx_vld&&atx_rdy, pop when the head order's final output beat is accepted; push and pop in the same cycle when full SHALL NOT be allowed (atx_rdy low).
REQ-023 SHALL run FSM IDLE (queue empty), XFER, PAD, DRAIN; IDLE->XFER when queue non-empty.
REQ-024 XFER: s_tready_o = !out_vld || atx_rdata_rdy; each accepted beat loads a one-entry output register (latency exactly 1 cycle) with data bytes whose tkeep bit is 0 forced to 0x00; beat counter increments from 0.
REQ-025 Final beat is counter==arlen; atx_rdata_last=1 on it; on acceptance, FSM returns to XFER (next order) or IDLE.
REQ-026 Early tlast (tlast with counter<arlen): beat forwarded, error set for head channel, FSM->PAD; PAD holds s_tready_o=0 and emits all-zero beats until counter==arlen, last beat flagged.
REQ-027 Late tlast (counter==arlen, tlast=0): beat forwarded as last, error set, FSM->DRAIN; DRAIN holds s_tready_o=1, discards beats through and including the next tlast, then next order/IDLE.
REQ-028 TID mismatch (s_tid_i != head arid) on any accepted beat SHALL set the head channel's error; data still forwarded.
REQ-029 atx_src_err[c] SHALL stay set until atx_err_clr[c]; simultaneous set and clear SHALL leave it set.
REQ-030 atx_rdata, _last, _chn SHALL hold stable while atx_rdata_vld&&!atx_rdata_rdy.
REQ-031 s_tready_o SHALL be 0 in IDLE; stream beats never dropped except in DRAIN.

Reset
REQ-032 On areset: queue empty, FSM IDLE, counter 0, atx_rdata_vld 0, atx_rdata/last/chn 0, s_tready_o 0, atx_rdy 0 during reset then 1, all atx_src_err 0; reset mid-transfer abandons the in-flight order with no further beats.

Structure
REQ-033 adma_pkg SHALL hold the FSM state enum and the order record typedef (arid, arlen, chn); CHN_W is a local derived constant.
REQ-034 The order queue SHALL be one sub-module, sync_fifo (depth ATX_NUM_OSTD, width of order record).

Verification
REQ-035 Order (id 3, arlen 3, chn 1) + 4 beats TID 3, tlast on 4th -> 4 output beats, last on 4th, chn=1, no error.
REQ-036 arlen 3, tlast on beat 2 -> beats 1-2 data, beats 3-4 zero, last on 4th, atx_src_err[1]=1 until clear.
REQ-037 arlen 1, tlast on beat 4 -> 2 output beats, beats 3-4 discarded, error set, next order's data unaffected.
REQ-038 Fill ATX_NUM_OSTD orders with no stream -> atx_rdy=0; one completes -> atx_rdy=1 next cycle.
REQ-039 Random atx_rdata_rdy backpressure over 64 beats, tkeep=0x0F -> output stable while stalled, upper bytes zero, no loss/duplication.
